// File: rtl/cnt_2_10_r.sv
// cnt_2_10_r: synchronous decade (mod-10) up/down counter.
// dir = 0 counts up 0..9 and wraps 9 -> 0; dir = 1 counts down and wraps 0 -> 9.
// reset is synchronous and active-high and has priority over dir.
// Codes 10..15 can only be present before the first reset. Any of them
// returns to 0 on the next non-reset edge, whatever the direction.
module cnt_2_10_r (
    input  logic       clk,
    input  logic       reset,
    input  logic       dir,
    output logic [3:0] cntQ
);

    logic [3:0] count;
    logic [3:0] count_next;

    // Next count: recovery from an illegal code, otherwise wrap-aware step in the selected direction
    always_comb begin
        count_next = '0;
        if (count > 4'd9) begin
            count_next = '0;
        end else if (!dir) begin
            count_next = (count == 4'd9) ? 4'd0 : count + 4'd1;
        end else begin
            count_next = (count == 4'd0) ? 4'd9 : count - 4'd1;
        end
    end

    // State register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign cntQ = count;

endmodule

// File: tb/tb_cnt_2_10_r.sv
// Bench for cnt_2_10_r. A modular-arithmetic reference model is checked
// against the DUT on every falling edge. Directed literal checks tie both
// the DUT and the model to fixed expected values.
module tb_cnt_2_10_r;

    logic       clk;
    logic       reset;
    logic       dir;
    logic [3:0] cntQ;

    int n_cmp;
    int n_bad;
    int model;
    bit model_valid;

    cnt_2_10_r dut (
        .clk  (clk),
        .reset(reset),
        .dir  (dir),
        .cntQ (cntQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal digit arithmetic modulo 10
    always @(posedge clk) begin
        if (reset) begin
            model       = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            model = dir ? (model + 9) % 10 : (model + 1) % 10;
        end
    end

    // Per-cycle comparison, sampled away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            n_cmp++;
            if (cntQ !== model[3:0]) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t cntQ=%0d expected=%0d", $time, cntQ, model);
            end
        end
    end

    task automatic cycle(input logic r, input logic d);
        reset = r;
        dir   = d;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int exp);
        n_cmp++;
        if (cntQ !== exp[3:0]) begin
            n_bad++;
            $display("FAIL %s cntQ=%0d expected=%0d", name, cntQ, exp);
        end
        n_cmp++;
        if (model != exp) begin
            n_bad++;
            $display("FAIL %s_model model=%0d expected=%0d", name, model, exp);
        end
    endtask

    int up_seq[12]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int down_seq[12] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        model       = 0;
        model_valid = 1'b0;
        reset       = 1'b1;
        dir         = 1'b0;
        @(negedge clk);

        // Reset and hold
        cycle(1'b1, 1'b0);
        chk("reset", 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            chk("reset_hold", 0);
        end

        // Up count with wrap
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0);
            chk("up_seq", up_seq[i]);
        end

        // Reset mid-count at 7
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        chk("up_to_7", 7);
        cycle(1'b1, 1'b0);
        chk("mid_reset", 0);
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 1'b0);
            chk("after_reset", i);
        end

        // Down count with wrap from 0
        cycle(1'b1, 1'b0);
        chk("reset_before_down", 0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1);
            chk("down_seq", down_seq[i]);
        end

        // Direction switch at 5 and again at 2
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        chk("up_to_5", 5);
        for (int i = 4; i >= 2; i--) begin
            cycle(1'b0, 1'b1);
            chk("switch_down", i);
        end
        for (int i = 3; i <= 4; i++) begin
            cycle(1'b0, 1'b0);
            chk("switch_up", i);
        end

        // Reset has priority over dir = 1 at 0 (no wrap to 9)
        cycle(1'b1, 1'b0);
        chk("reset_zero", 0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1);
            chk("reset_prio_down", 0);
        end

        // Random direction with occasional reset; the negedge compare checks each cycle
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(15) == 0), $urandom_range(1));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
